// File: rtl/multi_logic_pkg.sv
// Shared definitions for multi_logic_pipe: op encodings and per-op helpers.
// Optional feature macro used by the top: MULTI_LOGIC_PIPE_PARITY_EN.
package multi_logic_pkg;

  // Function select; encodings 6 and 7 are illegal.
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  localparam logic [2:0] OP_ILLEGAL_MIN = 3'd6;

  // Per-bit identity of the underlying reduction: 1 for AND/NAND, 0 otherwise.
  // Ops are bitwise, so the full-width identity is this bit replicated.
  function automatic logic op_identity(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  // True for ops that invert the reduced value.
  function automatic logic op_inverts(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready payload register; loads when empty or when downstream
// accepts. Ready is combinational so stalls propagate upstream in one cycle.
// Ports: clk, rst (async active-low), valid_i/ready_o/data_i upstream side,
//        valid_o/ready_i/data_o downstream side.
module pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  // Next-state: payload only changes when a new item is captured.
  always_comb begin
    load    = !valid_q || ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = load;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/multi_logic_pipe.sv
// Two-stage valid/ready pipeline computing a selectable bitwise function over
// up to NUM_OPERANDS masked WIDTH-bit operands. S1 holds op/mask/data, S2 holds
// result and flags. Optional feature: MULTI_LOGIC_PIPE_PARITY_EN adds out_parity.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_op/in_mask/in_data,
//        out_valid/out_ready/out_y/out_zero/out_err [/out_parity].
module multi_logic_pipe
  import multi_logic_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_OPERANDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [NUM_OPERANDS-1:0]       in_mask,
  input  logic [NUM_OPERANDS*WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_y,
  output logic                          out_zero,
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
  output logic                          out_parity,
`endif
  output logic                          out_err
);

  localparam int unsigned DATA_W = NUM_OPERANDS * WIDTH;
  localparam int unsigned S1_W   = 3 + NUM_OPERANDS + DATA_W;
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
  localparam int unsigned S2_W   = WIDTH + 3;
`else
  localparam int unsigned S2_W   = WIDTH + 2;
`endif

  logic [S1_W-1:0]         s1_q;
  logic                    s1_valid;
  logic                    s2_ready;
  logic [2:0]              s1_op;
  logic [NUM_OPERANDS-1:0] s1_mask;
  logic [DATA_W-1:0]       s1_data;
  logic [WIDTH-1:0]        operand;
  logic [WIDTH-1:0]        y_c;
  logic                    err_c;
  logic [S2_W-1:0]         s2_d;
  logic [S2_W-1:0]         s2_q;

  pipe_stage #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  ({in_op, in_mask, in_data}),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_q)
  );

  assign s1_op   = s1_q[S1_W-1 -: 3];
  assign s1_mask = s1_q[DATA_W +: NUM_OPERANDS];
  assign s1_data = s1_q[DATA_W-1:0];

  // Reduce masked operands; disabled slots contribute the op identity.
  always_comb begin
    operand = '0;
    y_c     = {WIDTH{op_identity(s1_op)}};
    err_c   = (s1_op >= OP_ILLEGAL_MIN);
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      operand = s1_mask[i] ? s1_data[i*WIDTH +: WIDTH] : {WIDTH{op_identity(s1_op)}};
      case (s1_op)
        OP_AND, OP_NAND: y_c = y_c & operand;
        OP_OR,  OP_NOR:  y_c = y_c | operand;
        default:         y_c = y_c ^ operand;
      endcase
    end
    if (op_inverts(s1_op)) y_c = ~y_c;
    if (err_c)             y_c = '0;
  end

`ifdef MULTI_LOGIC_PIPE_PARITY_EN
  assign s2_d = {err_c, (y_c == '0), ^y_c, y_c};
`else
  assign s2_d = {err_c, (y_c == '0), y_c};
`endif

  pipe_stage #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_d),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2_q)
  );

  assign out_y    = s2_q[WIDTH-1:0];
  assign out_err  = s2_q[S2_W-1];
  assign out_zero = s2_q[S2_W-2];
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
  assign out_parity = s2_q[WIDTH];
`endif

endmodule

// File: tb/tb_multi_logic_pipe.sv
// Directed self-checking bench for multi_logic_pipe (WIDTH=8, NUM_OPERANDS=4).
module tb_multi_logic_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [3:0]  in_mask = 4'd0;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_y;
  logic        out_zero;
  logic        out_err;
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
  logic        out_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_logic_pipe #(.WIDTH(8), .NUM_OPERANDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero),
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One item through an idle pipeline; checks latency and result flags.
  task automatic send_one(input string tag, input logic [2:0] op, input logic [3:0] mask,
                          input logic [31:0] data, input logic [7:0] ey,
                          input logic ez, input logic ee);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_mask   = mask;
    in_data   = data;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".y"},     32'(out_y),     32'(ey));
    check({tag, ".zero"},  32'(out_zero),  32'(ez));
    check({tag, ".err"},   32'(out_err),   32'(ee));
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
    check({tag, ".par"},   32'(out_parity), 32'(^ey));
`endif
  endtask

  logic [7:0] exp_q [10];
  int tx, rx;

  initial begin
    // Reset state
    #12;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_y",     32'(out_y),     32'd0);
    check("rst.out_zero",  32'(out_zero),  32'd0);
    check("rst.out_err",   32'(out_err),   32'd0);
`ifdef MULTI_LOGIC_PIPE_PARITY_EN
    check("rst.out_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk); rst = 1'b1;

    // Directed vectors: {slot3,slot2,slot1,slot0}
    send_one("and_full",  3'd0, 4'b1111, 32'hFFF03CFF, 8'h30, 1'b0, 1'b0);
    send_one("xnor_mask", 3'd5, 4'b0101, 32'h3C0FFFA5, 8'h55, 1'b0, 1'b0);
    send_one("nand_m0",   3'd3, 4'b0000, 32'h12345678, 8'h00, 1'b1, 1'b0);
    send_one("or_m0",     3'd1, 4'b0000, 32'hFFFFFFFF, 8'h00, 1'b1, 1'b0);
    send_one("and_m0",    3'd0, 4'b0000, 32'h00000000, 8'hFF, 1'b0, 1'b0);
    send_one("ill7",      3'd7, 4'b1111, 32'hDEADBEEF, 8'h00, 1'b1, 1'b1);
    send_one("xor_after", 3'd2, 4'b1111, 32'h00040201, 8'h07, 1'b0, 1'b0);
    send_one("ill6",      3'd6, 4'b0011, 32'h000000FF, 8'h00, 1'b1, 1'b1);
    send_one("nor_mask",  3'd4, 4'b0011, 32'hFFFF300F, 8'hC0, 1'b0, 1'b0);

    // Stream of 10: AND, mask 0011, slot0 = 10+i, slot1 = FF -> y = 10+i
    for (int i = 0; i < 10; i++) exp_q[i] = 8'(8'h10 + i);
    tx = 0; rx = 0;
    @(posedge clk);
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (tx < 10);
      in_op     = 3'd0;
      in_mask   = 4'b0011;
      in_data   = {16'h0000, 8'hFF, 8'(8'h10 + tx)};
      #5;
      if (cyc < 15)
        check($sformatf("stream.in_ready%0d", cyc), 32'(in_ready),
              32'(!(cyc >= 3 && cyc <= 6)));
      if (out_valid && rx < 10) begin
        check($sformatf("stream.y%0d", rx), 32'(out_y), 32'(exp_q[rx]));
        if (out_ready) rx++;
      end else if (out_valid) begin
        check("stream.dup", 32'(out_valid), 32'd0);
      end
      if (in_valid && in_ready) tx++;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    check("stream.count", 32'(rx), 32'd10);
    check("stream.tail_valid", 32'(out_valid), 32'd0);

    // Reset with two items in flight
    out_ready = 1'b0;
    in_op = 3'd0; in_mask = 4'b1111; in_data = 32'hFFFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight.valid", 32'(out_valid), 32'd1);
    check("inflight.in_ready", 32'(in_ready), 32'd0);
    #2; rst = 1'b0; #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.in_ready",  32'(in_ready),  32'd1);
    check("arst.out_y",     32'(out_y),     32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst.valid%0d", k), 32'(out_valid), 32'd0);
    end
    send_one("post_rst", 3'd0, 4'b1111, 32'hFFF03CFF, 8'h30, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
